// File: rtl/mtr_pkg.sv
// Shared types and default constants for the motor speed ramp controller.
package mtr_pkg;

   localparam int unsigned SPD_W  = 11;
   localparam int unsigned STEP_W = 10;

   localparam int unsigned DEF_TICK_DIV   = 1024;
   localparam int unsigned DEF_STEP       = 8;
   localparam int unsigned DEF_BRAKE_STEP = 64;

   typedef logic signed [SPD_W-1:0] spd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RAMP  = 2'd1,
      ST_BRAKE = 2'd2
   } state_e;

endpackage : mtr_pkg

// File: rtl/spd_slew.sv
// One-tick slew: moves the current speed toward the target by at most step_i,
// never overshooting. Arithmetic is one bit wider so the full range cannot wrap.
module spd_slew
   import mtr_pkg::*;
(
   input  logic signed [SPD_W-1:0] cur_i,
   input  logic signed [SPD_W-1:0] tgt_i,
   input  logic [STEP_W-1:0]       step_i,
   output logic signed [SPD_W-1:0] nxt_o
);

   localparam int unsigned DW = SPD_W + 1;

   logic signed [DW-1:0] cur_x;
   logic signed [DW-1:0] diff_c;
   logic signed [DW-1:0] amt_c;
   logic signed [DW-1:0] nxt_x;
   logic [DW-1:0]        mag_c;
   logic [DW-1:0]        step_x;

   always_comb begin
      cur_x  = DW'(cur_i);
      diff_c = DW'(tgt_i) - cur_x;
      mag_c  = diff_c[DW-1] ? $unsigned(-diff_c) : $unsigned(diff_c);
      step_x = DW'(step_i);
      // Clamp the move to the remaining distance so the target is never passed.
      amt_c  = (mag_c < step_x) ? $signed(mag_c) : $signed(step_x);
      nxt_x  = diff_c[DW-1] ? (cur_x - amt_c) : (cur_x + amt_c);
      nxt_o  = SPD_W'(nxt_x);
   end

endmodule : spd_slew

// File: rtl/mtr_ramp_ctrl.sv
// Dual-side motor speed ramp controller: slews both outputs toward the
// commanded targets once per tick, with a faster emergency brake to zero.
module mtr_ramp_ctrl
   import mtr_pkg::*;
#(
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned STEP       = DEF_STEP,
   parameter int unsigned BRAKE_STEP = DEF_BRAKE_STEP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   input  logic signed [10:0] tgt_lft,
   input  logic signed [10:0] tgt_rght,
   input  logic               estop,
   output logic signed [10:0] lft_spd,
   output logic signed [10:0] rght_spd,
   output logic               at_tgt,
   output logic               busy
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   spd_t             tgt_l_q, tgt_l_d;
   spd_t             tgt_r_q, tgt_r_d;
   spd_t             lft_q, lft_d;
   spd_t             rght_q, rght_d;

   logic              tick_c;
   logic              accept_c;
   logic [STEP_W-1:0] step_c;
   spd_t              nxt_l_c;
   spd_t              nxt_r_c;

   assign tick_c   = (cnt_q == CNT_W'(TICK_DIV - 1));
   assign cmd_rdy  = !estop && (state_q != ST_BRAKE);
   assign accept_c = cmd_vld && cmd_rdy;
   assign step_c   = (state_q == ST_BRAKE) ? STEP_W'(BRAKE_STEP) : STEP_W'(STEP);
   assign cnt_d    = tick_c ? '0 : (cnt_q + CNT_W'(1));

   assign lft_spd  = lft_q;
   assign rght_spd = rght_q;
   assign at_tgt   = (lft_q == tgt_l_q) && (rght_q == tgt_r_q);
   assign busy     = (state_q != ST_IDLE);

   spd_slew u_slew_lft (
      .cur_i  (lft_q),
      .tgt_i  (tgt_l_q),
      .step_i (step_c),
      .nxt_o  (nxt_l_c)
   );

   spd_slew u_slew_rght (
      .cur_i  (rght_q),
      .tgt_i  (tgt_r_q),
      .step_i (step_c),
      .nxt_o  (nxt_r_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tgt_l_q <= '0;
         tgt_r_q <= '0;
         lft_q   <= '0;
         rght_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_l_q <= tgt_l_d;
         tgt_r_q <= tgt_r_d;
         lft_q   <= lft_d;
         rght_q  <= rght_d;
      end
   end

   // Outputs move only on ticks and always use the targets held before this edge.
   always_comb begin
      state_d = state_q;
      tgt_l_d = tgt_l_q;
      tgt_r_d = tgt_r_q;
      lft_d   = tick_c ? nxt_l_c : lft_q;
      rght_d  = tick_c ? nxt_r_c : rght_q;

      case (state_q)
         ST_IDLE, ST_RAMP: begin
            if (estop) begin
               state_d = ST_BRAKE;
               tgt_l_d = '0;
               tgt_r_d = '0;
            end else begin
               if (accept_c) begin
                  tgt_l_d = tgt_lft;
                  tgt_r_d = tgt_rght;
               end
               state_d = ((lft_d == tgt_l_d) && (rght_d == tgt_r_d)) ? ST_IDLE : ST_RAMP;
            end
         end
         ST_BRAKE: begin
            tgt_l_d = '0;
            tgt_r_d = '0;
            if (!estop && (lft_q == '0) && (rght_q == '0)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule : mtr_ramp_ctrl
